// File: rtl/pico_irq_pkg.sv
// Shared definitions for the KCPSM6 interrupt controller: register offsets,
// FSM encoding and STATUS register layout.
package pico_irq_pkg;

  localparam logic [1:0] OFS_PEND = 2'd0;
  localparam logic [1:0] OFS_MASK = 2'd1;
  localparam logic [1:0] OFS_STAT = 2'd2;
  localparam logic [1:0] OFS_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  localparam int unsigned STAT_INSVC_BIT = 7;
  localparam int unsigned STAT_IRQ_BIT   = 6;

  function automatic logic [7:0] status_word(input logic in_svc, input logic irq,
                                             input logic [2:0] idx);
    logic [7:0] s;
    s                 = '0;
    s[STAT_INSVC_BIT] = in_svc;
    s[STAT_IRQ_BIT]   = irq;
    s[2:0]            = idx;
    return s;
  endfunction

endpackage

// File: rtl/pico_irq_if.sv
// Processor port bus plus interrupt handshake between KCPSM6 and the
// interrupt controller.
interface pico_irq_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] rd_data;
  logic       rd_sel;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  interrupt, rd_data, rd_sel
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output interrupt, rd_data, rd_sel
  );
endinterface

// File: rtl/pico_irq_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending sources.
module pico_irq_prio_enc
  import pico_irq_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic [2:0]       idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i] && !any) begin
        idx = 3'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pico_irq_ctrl.sv
// KCPSM6 interrupt controller: edge-latched pending sources, mask, single
// interrupt/ack handshake and in-service hold until software EOI.
module pico_irq_ctrl
  import pico_irq_pkg::*;
#(
  parameter int unsigned N_SRC   = 8,
  parameter logic [7:0]  BASE_ID = 8'hF0
) (
  input  logic             clk,
  input  logic             cpu_reset,
  input  logic [N_SRC-1:0] irq_in,
  pico_irq_if.slave        bus
);

  logic [N_SRC-1:0] irq_prev, pending, mask;
  logic [N_SRC-1:0] rise, w1c_clr, ack_clr, enc_req;
  irq_state_t       state;
  logic [2:0]       active_idx, enc_idx;
  logic             enc_any, in_service, irq_q;
  logic [7:0]       rd_data_q, rd_mux;
  logic             rd_sel_q;
  logic             in_win, wr_en, ack_take;
  logic [1:0]       ofs;
  logic             unused_read_strobe;

  assign unused_read_strobe = bus.read_strobe;

  assign in_win   = (bus.port_id[7:2] == BASE_ID[7:2]);
  assign ofs      = bus.port_id[1:0];
  assign wr_en    = bus.write_strobe && in_win;
  assign rise     = irq_in & ~irq_prev;
  assign enc_req  = pending & mask;
  assign ack_take = (state == REQ) && bus.interrupt_ack;
  assign w1c_clr  = (wr_en && ofs == OFS_PEND) ? bus.out_port[N_SRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_take && (active_idx == 3'(i));
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_PEND: rd_mux[N_SRC-1:0] = pending;
      OFS_MASK: rd_mux[N_SRC-1:0] = mask;
      OFS_STAT: rd_mux = status_word(in_service, irq_q, active_idx);
      default:  rd_mux = '0;
    endcase
  end

  pico_irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req (enc_req),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      irq_prev   <= '0;
      pending    <= '0;
      mask       <= '0;
      state      <= IDLE;
      active_idx <= '0;
      in_service <= 1'b0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_sel_q   <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      // A rise in the same cycle as any clear leaves the bit set.
      pending  <= (pending & ~w1c_clr & ~ack_clr) | rise;
      if (wr_en && ofs == OFS_MASK) mask <= bus.out_port[N_SRC-1:0];
      rd_sel_q  <= in_win;
      rd_data_q <= rd_mux;
      case (state)
        IDLE: if (enc_any) begin
          active_idx <= enc_idx;
          irq_q      <= 1'b1;
          state      <= REQ;
        end
        REQ: if (bus.interrupt_ack) begin
          irq_q      <= 1'b0;
          in_service <= 1'b1;
          state      <= SVC;
        end
        SVC: if (wr_en && ofs == OFS_EOI) begin
          in_service <= 1'b0;
          active_idx <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.interrupt = irq_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_sel    = rd_sel_q;

endmodule

// File: tb/tb_pico_irq_ctrl.sv
// Directed and randomized bench for pico_irq_ctrl against a behavioural model.
module tb_pico_irq_ctrl;

  logic       clk = 1'b0;
  logic       cpu_reset;
  logic [7:0] irq_in;
  int         n_checks = 0;
  int         n_err    = 0;

  pico_irq_if bus_if ();

  pico_irq_ctrl #(.N_SRC(8), .BASE_ID(8'hF0)) dut (
    .clk       (clk),
    .cpu_reset (cpu_reset),
    .irq_in    (irq_in),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus "requesting" / "in service" flags.
  logic [7:0] m_prev, m_pend, m_mask, m_rd;
  logic [2:0] m_idx;
  logic       m_irq, m_svc, m_sel;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic       win, wr;
    logic [1:0] o;
    logic [7:0] np, nm, nr;
    logic [2:0] ni;
    logic       nirq, nsvc;
    if (cpu_reset) begin
      m_prev = 0; m_pend = 0; m_mask = 0; m_rd = 0; m_idx = 0;
      m_irq = 0; m_svc = 0; m_sel = 0;
      return;
    end
    win = (bus_if.port_id >= 8'hF0) && (bus_if.port_id <= 8'hF3);
    wr  = win && bus_if.write_strobe;
    o   = bus_if.port_id[1:0];
    np = m_pend; nm = m_mask; ni = m_idx; nirq = m_irq; nsvc = m_svc;
    if (wr && o == 0) np = np & ~bus_if.out_port;
    if (m_irq && bus_if.interrupt_ack) np = np & ~(8'd1 << m_idx);
    np = np | (irq_in & ~m_prev);
    if (wr && o == 1) nm = bus_if.out_port;
    case (o)
      2'd0: nr = m_pend;
      2'd1: nr = m_mask;
      2'd2: nr = {m_svc, m_irq, 3'b000, m_idx};
      default: nr = 8'h00;
    endcase
    if (m_irq) begin
      if (bus_if.interrupt_ack) begin nirq = 0; nsvc = 1; end
    end else if (m_svc) begin
      if (wr && o == 3) begin nsvc = 0; ni = 0; end
    end else if ((m_pend & m_mask) != 0) begin
      nirq = 1; ni = 3'(lowest(m_pend & m_mask));
    end
    m_prev = irq_in; m_pend = np; m_mask = nm; m_idx = ni;
    m_irq = nirq; m_svc = nsvc; m_rd = nr; m_sel = win;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("interrupt", {7'b0, bus_if.interrupt}, {7'b0, m_irq});
    chk("rd_sel", {7'b0, bus_if.rd_sel}, {7'b0, m_sel});
    chk("rd_data", bus_if.rd_data, m_rd);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_if.port_id = a; bus_if.out_port = d; bus_if.write_strobe = 1'b1;
    tick();
    bus_if.write_strobe = 1'b0; bus_if.port_id = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus_if.port_id = a; bus_if.read_strobe = 1'b1;
    tick();
    bus_if.read_strobe = 1'b0;
    chk(tag, bus_if.rd_data, exp);
    bus_if.port_id = 8'h00;
  endtask

  task automatic ack_pulse();
    bus_if.interrupt_ack = 1'b1;
    tick();
    bus_if.interrupt_ack = 1'b0;
  endtask

  initial begin
    int seen;
    cpu_reset = 1'b1; irq_in = '0;
    bus_if.port_id = '0; bus_if.out_port = '0; bus_if.write_strobe = 1'b0;
    bus_if.read_strobe = 1'b0; bus_if.interrupt_ack = 1'b0;
    tick(); tick();
    cpu_reset = 1'b0;

    // 1: reset state, quiet for 100 cycles
    rd_chk("t1_mask", 8'hF1, 8'h00);
    rd_chk("t1_pend", 8'hF0, 8'h00);
    rd_chk("t1_stat", 8'hF2, 8'h00);
    seen = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (bus_if.interrupt) seen++; end
    chk("t1_quiet", 8'(seen), 8'h00);

    // 2: single source, latency, ack, EOI
    wr(8'hF1, 8'h05);
    irq_in = 8'h04; tick(); irq_in = 8'h00;
    chk("t2_not_yet", {7'b0, bus_if.interrupt}, 8'h00);
    tick();
    chk("t2_latency", {7'b0, bus_if.interrupt}, 8'h01);
    ack_pulse();
    chk("t2_drop", {7'b0, bus_if.interrupt}, 8'h00);
    rd_chk("t2_stat", 8'hF2, 8'h82);
    rd_chk("t2_pend", 8'hF0, 8'h00);
    wr(8'hF3, 8'h00);
    rd_chk("t2_stat_eoi", 8'hF2, 8'h00);

    // 3: priority, then re-arbitration after EOI
    wr(8'hF1, 8'hFF);
    irq_in = 8'h42; tick(); irq_in = 8'h00; tick();
    rd_chk("t3_req1", 8'hF2, 8'h41);
    ack_pulse();
    rd_chk("t3_svc1", 8'hF2, 8'h81);
    wr(8'hF3, 8'h00);
    chk("t3_gap", {7'b0, bus_if.interrupt}, 8'h00);
    tick();
    chk("t3_rearb", {7'b0, bus_if.interrupt}, 8'h01);
    rd_chk("t3_req2", 8'hF2, 8'h46);
    ack_pulse();
    wr(8'hF3, 8'h00);

    // 4: masked source, W1C
    wr(8'hF1, 8'h00);
    irq_in = 8'h08; tick(); irq_in = 8'h00; tick();
    rd_chk("t4_pend", 8'hF0, 8'h08);
    chk("t4_masked", {7'b0, bus_if.interrupt}, 8'h00);
    wr(8'hF0, 8'h08);
    rd_chk("t4_w1c", 8'hF0, 8'h00);
    wr(8'hF1, 8'h08);
    tick(); tick();
    chk("t4_no_irq", {7'b0, bus_if.interrupt}, 8'h00);

    // 5: rise beats W1C
    irq_in = 8'h10; wr(8'hF0, 8'h10); irq_in = 8'h00;
    rd_chk("t5_rise_wins", 8'hF0, 8'h10);
    wr(8'hF0, 8'h10);

    // 6: reset in REQ, late ack ignored
    wr(8'hF1, 8'hFF);
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
    chk("t6_req", {7'b0, bus_if.interrupt}, 8'h01);
    cpu_reset = 1'b1; tick(); cpu_reset = 1'b0;
    chk("t6_reset", {7'b0, bus_if.interrupt}, 8'h00);
    ack_pulse();
    chk("t6_late_ack", {7'b0, bus_if.interrupt}, 8'h00);
    rd_chk("t6_pend", 8'hF0, 8'h00);
    rd_chk("t6_mask", 8'hF1, 8'h00);
    rd_chk("t6_stat", 8'hF2, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) irq_in = 8'($urandom);
      bus_if.interrupt_ack = (bus_if.interrupt && $urandom_range(2) == 0) ||
                             ($urandom_range(19) == 0);
      bus_if.write_strobe  = ($urandom_range(5) < 2);
      bus_if.read_strobe   = ($urandom_range(1) == 0);
      bus_if.port_id       = ($urandom_range(7) == 0) ? 8'($urandom)
                                                      : 8'hF0 + 8'($urandom_range(3));
      bus_if.out_port      = 8'($urandom);
      cpu_reset            = ($urandom_range(499) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
